serial_mult_arbiter: RTL

- Shares one shift-add serial multiplier between N requesters.
- Round-robin arbitration with a per-requester REQ/GNT handshake.
- Latches the winner's operands, runs W shift-add steps MSB-first, returns the product with a one-hot completion pulse.
- Sits between client blocks and the single multiplier datapath.

---
 rtl/serial_mult_arbiter_pkg.sv | 20 ++
 rtl/serial_mult_arbiter_if.sv | 34 +++
 rtl/serial_mult_arbiter_core.sv | 64 ++++++
 rtl/serial_mult_arbiter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/serial_mult_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// serial_mult_arbiter_pkg : shared state encodings and parameter defaults
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_mult_arbiter_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_mult_arbiter_if.sv
// ---------------------------------------------------------------------------
// serial_mult_arbiter_if : request/operand/result bundle between clients and arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface serial_mult_arbiter_if
  import serial_mult_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);

  logic [N-1:0]   REQ;
  logic [N*W-1:0] A_FLAT;
  logic [N*W-1:0] B_FLAT;
  logic [N-1:0]   GNT;
  logic [2*W-1:0] P_OUT;
  logic [N-1:0]   DONE_VLD;
  logic           BUSY;

  modport master (
    output REQ, A_FLAT, B_FLAT,
    input  GNT, P_OUT, DONE_VLD, BUSY
  );

  modport slave (
    input  REQ, A_FLAT, B_FLAT,
    output GNT, P_OUT, DONE_VLD, BUSY
  );

endinterface

`default_nettype wire

// File: rtl/serial_mult_arbiter_core.sv
// ---------------------------------------------------------------------------
// serial_mult_core : MSB-first shift-add multiplier, W steps after a LOAD pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_mult_core
  import serial_mult_arbiter_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           LOAD,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic [2*W-1:0] P,
  output logic           DONE
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]   a_q;
  logic [W-1:0]   m_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_d;
  logic [CW-1:0]  cnt_q;
  logic           run_q;

  always_comb begin
    acc_d = (acc_q << 1) + (m_q[W-1] ? {{W{1'b0}}, a_q} : {(2*W){1'b0}});
  end

  // P is the value the accumulator takes on this edge, so the final step can
  // be captured by the caller on the same edge that DONE is high.
  assign P    = acc_d;
  assign DONE = run_q && (cnt_q == CW'(W - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q   <= '0;
      m_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (LOAD) begin
      a_q   <= A;
      m_q   <= B;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_d;
      m_q   <= m_q << 1;
      cnt_q <= cnt_q + 1'b1;
      if (DONE) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_mult_arbiter.sv
// ---------------------------------------------------------------------------
// serial_mult_arbiter : round-robin arbiter sharing one serial multiplier among N clients
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_mult_arbiter
  import serial_mult_arbiter_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int W   = DEF_W,
  parameter int IDW = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  serial_mult_arbiter_if.slave  bus
);

  localparam int             IDXW  = IDW + 1;
  localparam logic [N-1:0]   ONE_N = {{(N-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] win_q, win_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [N-1:0]   done_q, done_d;
  logic [2*W-1:0] pout_q, pout_d;
  logic           busy_q;

  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic [IDXW-1:0] idx_ext;
  int             sel_base;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic           load;
  logic [2*W-1:0] core_p;
  logic           core_done;

  // Rotating priority search starting at ptr_q; one extra bit so the wrap
  // subtraction never overflows.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx_ext  = '0;
    for (int k = 0; k < N; k++) begin
      idx_ext = {1'b0, ptr_q} + IDXW'(k);
      if (idx_ext >= IDXW'(N)) begin
        idx_ext = idx_ext - IDXW'(N);
      end
      if (!pick_vld && bus.REQ[idx_ext[IDW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = idx_ext[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_base = int'(pick_idx) * W;
    a_sel    = bus.A_FLAT[sel_base +: W];
    b_sel    = bus.B_FLAT[sel_base +: W];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = '0;
    done_d  = '0;
    pout_d  = pout_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          load    = 1'b1;
          win_d   = pick_idx;
          gnt_d   = ONE_N << pick_idx;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (core_done) begin
          pout_d  = core_p;
          done_d  = ONE_N << win_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = (win_q == IDW'(N - 1)) ? '0 : win_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      pout_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      pout_q  <= pout_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  serial_mult_core #(
    .W (W)
  ) u_core (
    .CLK  (CLK),
    .RST  (RST),
    .LOAD (load),
    .A    (a_sel),
    .B    (b_sel),
    .P    (core_p),
    .DONE (core_done)
  );

  assign bus.GNT      = gnt_q;
  assign bus.DONE_VLD = done_q;
  assign bus.P_OUT    = pout_q;
  assign bus.BUSY     = busy_q;

endmodule

`default_nettype wire
